// File: rtl/matrix_result_streamer.sv
// Matrix result streamer: double-buffers 4x4 result matrices from the
// systolic array and streams them row-major over a valid/ready port.
//
// Ports:
//   i_clk         clock, rising edge
//   i_arst        asynchronous active-high reset
//   i_c           result matrix, i_c[r][c] = row r, column c
//   i_validResult one-cycle pulse, i_c valid in the same cycle
//   i_ready       downstream accepts o_data
//   o_data        current streamed element
//   o_valid       o_data valid (ACTIVE buffer full)
//   o_row/o_col   indices of o_data
//   o_last        o_data is element [3][3]
//   o_busy        any buffer holds a matrix
//   o_dropCount   matrices dropped, saturating at 255
module matrix_result_streamer #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                          i_clk,
    input  logic                          i_arst,
    input  logic [N-1:0][N-1:0][W-1:0]    i_c,
    input  logic                          i_validResult,
    input  logic                          i_ready,
    output logic [W-1:0]                  o_data,
    output logic                          o_valid,
    output logic [1:0]                    o_row,
    output logic [1:0]                    o_col,
    output logic                          o_last,
    output logic                          o_busy,
    output logic [7:0]                    o_dropCount
);

    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

    mat_t       act_q, act_d;
    mat_t       pend_q, pend_d;
    logic       act_full_q, act_full_d;
    logic       pend_full_q, pend_full_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] drop_q, drop_d;

    logic xfer;
    logic last_xfer;

    assign xfer      = act_full_q && i_ready;
    assign last_xfer = xfer && (idx_q == 4'd15);

    always_comb begin
        act_d       = act_q;
        pend_d      = pend_q;
        act_full_d  = act_full_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        drop_d      = drop_q;

        if (xfer) begin
            idx_d = idx_q + 4'd1;
        end

        // End of matrix: promote PENDING without a bubble, else go idle.
        if (last_xfer) begin
            if (pend_full_q) begin
                act_d       = pend_q;
                pend_full_d = 1'b0;
                idx_d       = 4'd0;
            end else begin
                act_full_d = 1'b0;
            end
        end

        // Capture decisions use start-of-cycle flags; a last transfer
        // frees exactly one slot in the same cycle.
        if (i_validResult) begin
            if (!act_full_q || (last_xfer && !pend_full_q)) begin
                act_d      = i_c;
                act_full_d = 1'b1;
                idx_d      = 4'd0;
            end else if (!pend_full_q || last_xfer) begin
                pend_d      = i_c;
                pend_full_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            act_q       <= '0;
            pend_q      <= '0;
            act_full_q  <= 1'b0;
            pend_full_q <= 1'b0;
            idx_q       <= 4'd0;
            drop_q      <= 8'd0;
        end else begin
            act_q       <= act_d;
            pend_q      <= pend_d;
            act_full_q  <= act_full_d;
            pend_full_q <= pend_full_d;
            idx_q       <= idx_d;
            drop_q      <= drop_d;
        end
    end

    assign o_data      = act_q[idx_q[3:2]][idx_q[1:0]];
    assign o_valid     = act_full_q;
    assign o_row       = idx_q[3:2];
    assign o_col       = idx_q[1:0];
    assign o_last      = act_full_q && (idx_q == 4'd15);
    assign o_busy      = act_full_q || pend_full_q;
    assign o_dropCount = drop_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer: table-driven matrix
// sequences plus hand-written corner cases, checked by a scoreboard.
module tb_matrix_result_streamer;

    typedef logic [3:0][3:0][15:0] mat_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        l;
    } exp_t;

    typedef struct {
        int          kind;     // 0 ramp r*4+c+1, 1 constant fill
        logic [15:0] fill;
        bit          toggle;   // i_ready toggles while draining
        int          gap;      // -1 drain, else idle cycles before next
        int          span;     // expected valid span of group, 0 = skip
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_arst;
    mat_t        i_c;
    logic        i_validResult;
    logic        i_ready;
    logic [15:0] o_data;
    logic        o_valid;
    logic [1:0]  o_row;
    logic [1:0]  o_col;
    logic        o_last;
    logic        o_busy;
    logic [7:0]  o_dropCount;

    matrix_result_streamer #(.N(4), .W(16)) dut (
        .i_clk         (i_clk),
        .i_arst        (i_arst),
        .i_c           (i_c),
        .i_validResult (i_validResult),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_row         (o_row),
        .o_col         (o_col),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_dropCount   (o_dropCount)
    );

    always #5 i_clk = ~i_clk;

    exp_t sbq[$];
    int   errs = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   vcnt = 0;
    int   vfirst = 0;
    int   vlast = 0;

    logic        hold_v = 1'b0;
    logic [15:0] hd;
    logic [1:0]  hr;
    logic [1:0]  hc;
    logic        hl;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sampled on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        cyc++;
        if (i_arst) begin
            hold_v = 1'b0;
        end else if (mon_en) begin
            if (o_valid) begin
                if (vcnt == 0) vfirst = cyc;
                vlast = cyc;
                vcnt++;
            end
            if (hold_v) begin
                chk("hold_data", o_data, hd);
                chk("hold_row", o_row, hr);
                chk("hold_col", o_col, hc);
                chk("hold_last", o_last, hl);
            end
            hold_v = o_valid && !i_ready;
            hd = o_data;
            hr = o_row;
            hc = o_col;
            hl = o_last;
            if (o_valid && i_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", o_data, 32'hDEAD);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("data", o_data, e.d);
                    chk("row", o_row, e.r);
                    chk("col", o_col, e.c);
                    chk("last", o_last, e.l);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic mat_t mk(int kind, logic [15:0] base);
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = (kind == 0) ? 16'(base + r * 4 + c + 1) : base;
        return m;
    endfunction

    task automatic pulse(mat_t m, bit accept);
        i_c = m;
        i_validResult = 1'b1;
        if (accept) begin
            for (int k = 0; k < 16; k++) begin
                exp_t e;
                e.d = m[k / 4][k % 4];
                e.r = 2'(k / 4);
                e.c = 2'(k % 4);
                e.l = (k == 15);
                sbq.push_back(e);
            end
        end
        tick();
        i_validResult = 1'b0;
    endtask

    task automatic drain(bit tog);
        for (int i = 0; i < 300; i++) begin
            if (sbq.size() == 0 && !o_valid) break;
            if (tog) i_ready = ~i_ready;
            tick();
        end
        chk("drain_done", {31'd0, sbq.size() == 0 && !o_valid}, 32'd1);
        chk("busy_after_drain", o_busy, 1'b0);
        i_ready = 1'b1;
    endtask

    vec_t vecs[4];

    initial begin
        mat_t m;

        vecs[0] = '{0, 16'h0000, 1'b0, -1, 16};
        vecs[1] = '{0, 16'h0000, 1'b1, -1, 0};
        vecs[2] = '{1, 16'h0A0A, 1'b0, 1, 0};
        vecs[3] = '{1, 16'hB0B0, 1'b0, -1, 32};

        i_arst = 1'b1;
        i_c = '0;
        i_validResult = 1'b0;
        i_ready = 1'b1;
        #2;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_last", o_last, 1'b0);
        chk("rst_data", o_data, 16'h0);
        chk("rst_rowcol", {o_row, o_col}, 4'h0);
        chk("rst_drop", o_dropCount, 8'h0);
        tick();
        tick();
        i_arst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Table-driven sequences.
        for (int v = 0; v < 4; v++) begin
            bit fresh;
            fresh = (v == 0) || (vecs[v-1].gap < 0);
            if (fresh) vcnt = 0;
            pulse(mk(vecs[v].kind, vecs[v].fill), 1'b1);
            if (fresh) chk("capture_latency", o_valid, 1'b1);
            if (vecs[v].gap >= 0) begin
                repeat (vecs[v].gap) tick();
            end else begin
                drain(vecs[v].toggle);
                if (vecs[v].span != 0) begin
                    chk("valid_count", vcnt, vecs[v].span);
                    chk("valid_span", vlast - vfirst + 1, vecs[v].span);
                end
            end
        end

        // Two buffered, third dropped while stalled.
        i_ready = 1'b0;
        pulse(mk(1, 16'h1111), 1'b1);
        pulse(mk(1, 16'h2222), 1'b1);
        pulse(mk(1, 16'h3333), 1'b0);
        tick();
        chk("drop_count", o_dropCount, 8'd1);
        chk("busy_stalled", o_busy, 1'b1);
        i_ready = 1'b1;
        drain(1'b0);
        chk("drop_count_after", o_dropCount, 8'd1);

        // New capture coinciding with last transfer, PENDING empty.
        i_ready = 1'b1;
        pulse(mk(0, 16'h0100), 1'b1);
        repeat (15) tick();
        m = mk(0, 16'h0200);
        pulse(m, 1'b1);
        chk("handoff_valid", o_valid, 1'b1);
        chk("handoff_data", o_data, m[0][0]);
        chk("handoff_rowcol", {o_row, o_col}, 4'h0);
        drain(1'b0);

        // Reset mid-stream with PENDING full.
        pulse(mk(1, 16'h4444), 1'b1);
        pulse(mk(1, 16'h5555), 1'b1);
        repeat (6) tick();
        chk("pre_rst_row", o_row, 2'd1);
        chk("pre_rst_col", o_col, 2'd3);
        i_arst = 1'b1;
        #1;
        sbq.delete();
        chk("arst_valid", o_valid, 1'b0);
        chk("arst_busy", o_busy, 1'b0);
        chk("arst_drop", o_dropCount, 8'd0);
        chk("arst_data", o_data, 16'h0);
        tick();
        i_arst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", o_valid, 1'b0);
        end

        // Capture on the first edge after reset release.
        i_arst = 1'b1;
        tick();
        i_arst = 1'b0;
        m = mk(0, 16'h0300);
        pulse(m, 1'b1);
        chk("first_after_rst", o_valid, 1'b1);
        chk("first_after_rst_data", o_data, m[0][0]);
        drain(1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
